sign_extend_unit: RTL and testbench
===================================

// Module: sign_extend_unit
// PURPOSE
//   Immediate-extension stage of the single-cycle/pipelined MIPS-style CPU datapath.
//   Takes the 16-bit instruction immediate field and produces a registered 32-bit operand.
//   Supported extensions: sign-extend, zero-extend, load-upper (LUI) and byte sign-extend.
//   Also produces the word-aligned branch offset. Feeds the ALU B-mux and the branch adder.
// PARAMETERS
//   IN_W    16  width of immediate input a
//   OUT_W   32  width of extended outputs (must be >= 2*IN_W for LUI mode)
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      synchronous reset, active-low
//   in_valid   in   1      a/ext_op are valid this cycle; capture them
//   ext_op     in   2      00 sign16, 01 zero16, 10 lui, 11 sign8
//   a          in   IN_W   immediate field (instr[15:0])
//   out_valid  out  1      b/b_sl2 hold a result captured on the previous valid cycle
//   b          out  OUT_W  extended immediate
//   b_sl2      out  OUT_W  sign16(a) << 2, branch offset; independent of ext_op
// BEHAVIOUR
//   - One clock, one reset. Reset is synchronous and active-low: sampled only on the
//     rising edge of clk while rst_n==0.
//   - Reset values: b=0, b_sl2=0, out_valid=0. Reset has priority over in_valid.
//   - Latency is exactly 1 cycle. If in_valid==1 at edge N, then at edge N:
//     * b and b_sl2 update;
//     * out_valid goes to 1.
//   - If in_valid==0 at an edge: out_valid goes to 0. b and b_sl2 HOLD their last value,
//     so no spurious toggling occurs.
//   - No backpressure. A new input is accepted every cycle, giving back-to-back throughput
//     of 1 per clock.
//   - ext_op encodings:
//     * 00 sign16: b = {{16{a[15]}}, a[15:0]}
//     * 01 zero16: b = {16'h0000, a[15:0]}
//     * 10 lui:    b = {a[15:0], 16'h0000}
//     * 11 sign8:  b = {{24{a[7]}}, a[7:0]}; a[15:8] is ignored
//   - b_sl2 = {{14{a[15]}}, a[15:0], 2'b00}, computed from the same captured a.
//     It is always derived from sign16, whatever ext_op is.
//   - Purely arithmetic, with no saturation or overflow flag.
//     * Most-negative input 0x8000 maps to 0xFFFF8000.
//     * Most-positive input 0x7FFF maps to 0x00007FFF.
//   - Reset mid-stream: the result captured in the reset cycle is discarded. out_valid is
//     0 on the next edge, and the first valid input after rst_n rises appears one cycle
//     later as usual.
//   - All outputs are registered. There are no combinational paths from inputs to outputs.
//   - X on a while in_valid==0 must not propagate to the outputs.
// TESTING
//   1. Reset hold: rst_n=0 for 2 cycles with in_valid=1, a=16'h1234 -> b=0, b_sl2=0,
//      out_valid=0.
//   2. Sign16, back-to-back with ext_op=00:
//      * a=10 -> b=32'h0000000A, b_sl2=32'h00000028
//      * a=-10 (16'hFFF6) -> b=32'hFFFFFFF6, b_sl2=32'hFFFFFFD8
//      * a=88 -> b=32'h00000058
//      * a=-100 (16'hFF9C) -> b=32'hFFFFFF9C
//      Each result appears 1 cycle after its input, with out_valid=1 every cycle.
//   3. Modes on a=16'hFFF6:
//      * ext_op=01 -> b=32'h0000FFF6
//      * ext_op=10 -> b=32'hFFF60000
//      * ext_op=11 -> b=32'hFFFFFFF6
//      In all three cases b_sl2=32'hFFFFFFD8.
//   4. Boundaries, sign16:
//      * 16'h8000 -> 32'hFFFF8000
//      * 16'h7FFF -> 32'h00007FFF
//      * 16'h0000 -> 0
//      Sign8 on 16'h0080 -> 32'hFFFFFF80; sign8 on 16'hFF7F -> 32'h0000007F.
//   5. Hold: valid a=88, then in_valid=0 for 3 cycles with a driven to X -> b stays
//      32'h00000058 and out_valid=0.
//   6. Mid-stream reset: a stream of valid inputs with rst_n=0 for one cycle -> outputs
//      cleared, out_valid=0. The next valid a=10 yields b=32'h0000000A one cycle later.

Source files
------------

// File: rtl/sign_extend_unit_if.sv
// Immediate-extension bus: capture side (in_valid/ext_op/a) and registered result side.
// The master drives immediates and consumes results; the slave is the extension unit.
interface sign_extend_unit_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
);
    logic             in_valid;
    logic [1:0]       ext_op;
    logic [IN_W-1:0]  a;
    logic             out_valid;
    logic [OUT_W-1:0] b;
    logic [OUT_W-1:0] b_sl2;

    modport master (
        output in_valid, ext_op, a,
        input  out_valid, b, b_sl2
    );

    modport slave (
        input  in_valid, ext_op, a,
        output out_valid, b, b_sl2
    );
endinterface

// File: rtl/sign_extend_unit.sv
// Registered immediate extension (sign16/zero16/lui/sign8) plus the word-aligned
// branch offset; one result per clock, one cycle of latency.
module sign_extend_unit #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    sign_extend_unit_if.slave bus
);

    typedef enum logic [1:0] {
        EXT_SIGN16 = 2'b00,
        EXT_ZERO16 = 2'b01,
        EXT_LUI    = 2'b10,
        EXT_SIGN8  = 2'b11
    } ext_op_e;

    function automatic logic signed [OUT_W-1:0] extend_imm(
        input logic [1:0]      op,
        input logic [IN_W-1:0] imm
    );
        logic signed [OUT_W-1:0] res;
        res = '0;
        case (ext_op_e'(op))
            EXT_SIGN16: res = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
            EXT_ZERO16: res = {{(OUT_W-IN_W){1'b0}}, imm};
            EXT_LUI:    res = OUT_W'(imm) << IN_W;
            EXT_SIGN8:  res = {{(OUT_W-8){imm[7]}}, imm[7:0]};
            default:    res = '0;
        endcase
        return res;
    endfunction

    // Branch offset is always the sign16 value scaled to a word address.
    function automatic logic signed [OUT_W-1:0] branch_offset(
        input logic [IN_W-1:0] imm
    );
        return {{(OUT_W-IN_W-2){imm[IN_W-1]}}, imm, 2'b00};
    endfunction

    logic                    vld_d, vld_q;
    logic signed [OUT_W-1:0] b_d, b_q;
    logic signed [OUT_W-1:0] sl2_d, sl2_q;

    // Results hold when nothing is captured, so an undriven a never reaches the outputs.
    always_comb begin
        vld_d = bus.in_valid;
        b_d   = b_q;
        sl2_d = sl2_q;
        if (bus.in_valid) begin
            b_d   = extend_imm(bus.ext_op, bus.a);
            sl2_d = branch_offset(bus.a);
        end
    end

    // Output register stage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            b_q   <= '0;
            sl2_q <= '0;
        end else begin
            vld_q <= vld_d;
            b_q   <= b_d;
            sl2_q <= sl2_d;
        end
    end

    assign bus.out_valid = vld_q;
    assign bus.b         = b_q;
    assign bus.b_sl2     = sl2_q;

endmodule

// File: tb/tb_sign_extend_unit.sv
// Self-checking bench for sign_extend_unit: directed cases followed by a random
// stream compared against an arithmetic reference model.
module tb_sign_extend_unit;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    logic        exp_vld;
    logic [31:0] exp_b;
    logic [31:0] exp_sl2;

    sign_extend_unit_if #(.IN_W(16), .OUT_W(32)) bus ();

    sign_extend_unit #(.IN_W(16), .OUT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_ext(input logic [1:0] op, input logic [15:0] v);
        int s16;
        int s8;
        logic [7:0] lo;
        logic [31:0] r;
        lo  = v[7:0];
        s16 = $signed(v);
        s8  = $signed(lo);
        case (op)
            2'd0:    r = s16;
            2'd1:    r = 32'(v);
            2'd2:    r = 32'(v) * 32'd65536;
            default: r = s8;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] ref_sl2(input logic [15:0] v);
        int s16;
        s16 = $signed(v);
        return s16 * 4;
    endfunction

    // Called at a falling edge: drive, let one rising edge pass, check at the next falling edge.
    task automatic step(input string tag, input logic rst_v, input logic vld,
                        input logic [1:0] op, input logic [15:0] av);
        rst_n        = rst_v;
        bus.in_valid = vld;
        bus.ext_op   = op;
        bus.a        = av;
        @(posedge clk);
        if (!rst_v) begin
            exp_vld = 1'b0;
            exp_b   = '0;
            exp_sl2 = '0;
        end else if (vld) begin
            exp_vld = 1'b1;
            exp_b   = ref_ext(op, av);
            exp_sl2 = ref_sl2(av);
        end else begin
            exp_vld = 1'b0;
        end
        @(negedge clk);
        check_val({tag, ".vld"}, {31'd0, bus.out_valid}, {31'd0, exp_vld});
        check_val({tag, ".b"},   bus.b,     exp_b);
        check_val({tag, ".sl2"}, bus.b_sl2, exp_sl2);
    endtask

    task automatic step_idle_x(input string tag);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        bus.ext_op   = 2'bxx;
        bus.a        = 16'hxxxx;
        @(posedge clk);
        exp_vld = 1'b0;
        @(negedge clk);
        check_val({tag, ".vld"}, {31'd0, bus.out_valid}, {31'd0, exp_vld});
        check_val({tag, ".b"},   bus.b,     exp_b);
        check_val({tag, ".sl2"}, bus.b_sl2, exp_sl2);
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        exp_vld      = 1'b0;
        exp_b        = '0;
        exp_sl2      = '0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.ext_op   = 2'd0;
        bus.a        = 16'h0000;
        @(negedge clk);

        step("rst0", 1'b0, 1'b1, 2'd0, 16'h1234);
        step("rst1", 1'b0, 1'b1, 2'd0, 16'h1234);

        step("s16_p10",  1'b1, 1'b1, 2'd0, 16'd10);
        check_val("s16_p10.const", bus.b_sl2, 32'h00000028);
        step("s16_m10",  1'b1, 1'b1, 2'd0, 16'hFFF6);
        check_val("s16_m10.const", bus.b, 32'hFFFFFFF6);
        step("s16_p88",  1'b1, 1'b1, 2'd0, 16'd88);
        step("s16_m100", 1'b1, 1'b1, 2'd0, 16'hFF9C);
        check_val("s16_m100.const", bus.b, 32'hFFFFFF9C);

        step("zero16", 1'b1, 1'b1, 2'd1, 16'hFFF6);
        check_val("zero16.const", bus.b, 32'h0000FFF6);
        step("lui",    1'b1, 1'b1, 2'd2, 16'hFFF6);
        check_val("lui.const", bus.b, 32'hFFF60000);
        step("sign8",  1'b1, 1'b1, 2'd3, 16'hFFF6);
        check_val("sign8.sl2const", bus.b_sl2, 32'hFFFFFFD8);

        step("min16", 1'b1, 1'b1, 2'd0, 16'h8000);
        check_val("min16.const", bus.b, 32'hFFFF8000);
        step("max16", 1'b1, 1'b1, 2'd0, 16'h7FFF);
        check_val("max16.const", bus.b, 32'h00007FFF);
        step("zero",  1'b1, 1'b1, 2'd0, 16'h0000);
        step("s8neg", 1'b1, 1'b1, 2'd3, 16'h0080);
        check_val("s8neg.const", bus.b, 32'hFFFFFF80);
        step("s8pos", 1'b1, 1'b1, 2'd3, 16'hFF7F);
        check_val("s8pos.const", bus.b, 32'h0000007F);

        step("hold_ld", 1'b1, 1'b1, 2'd0, 16'd88);
        for (int i = 0; i < 3; i++) step_idle_x("hold");
        check_val("hold.const", bus.b, 32'h00000058);

        step("mr_a", 1'b1, 1'b1, 2'd0, 16'h1357);
        step("mr_b", 1'b1, 1'b1, 2'd2, 16'h2468);
        step("mr_rst", 1'b0, 1'b1, 2'd0, 16'h4321);
        step("mr_p10", 1'b1, 1'b1, 2'd0, 16'd10);
        check_val("mr_p10.const", bus.b, 32'h0000000A);

        for (int i = 0; i < 300; i++) begin
            step("rnd", ($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0),
                 2'($urandom_range(0, 3)), 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
